// File: rtl/pattern_det_pkg.sv
// rtl/pattern_det_pkg.sv - shared FSM state type and default pattern for the serial pattern detector
package pattern_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } det_state_t;

  localparam int DEF_PAT_W = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b11010;

endpackage

// File: rtl/pattern_match_cmp.sv
// rtl/pattern_match_cmp.sv - combinational masked compare of the next history word against the pattern
module pattern_match_cmp
  import pattern_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic [PAT_W-1:0] hist_nxt,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PAT_W-1:0] mask,
  output logic             hit
);

  assign hit = ((hist_nxt ^ pattern) & mask) == '0;

endmodule

// File: rtl/pattern_detector_param.sv
// rtl/pattern_detector_param.sv - programmable masked serial pattern detector with registered match pulse
// Optional saturating match counter enabled by PATTERN_DETECTOR_MATCH_CNT_EN.
module pattern_detector_param
  import pattern_det_pkg::*;
#(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] RST_PAT  = PAT_W'(DEF_PATTERN),
  parameter logic [PAT_W-1:0] RST_MASK = '1,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stream_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  output logic             pattern_found,
  output logic             busy_fill
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_params
    $error("pattern_detector_param: PAT_W must be 2..32 and CNT_W at least 1");
  end

  det_state_t        state;
  det_state_t        state_nxt;
  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_nxt;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  mask;
  logic              overlap;
  logic [FILL_W-1:0] fill;
  logic              accept;
  logic              complete;
  logic              hit;
  logic              match;

  assign hist_nxt = {hist[PAT_W-2:0], stream_in};

  pattern_match_cmp #(
    .PAT_W(PAT_W)
  ) u_cmp (
    .hist_nxt(hist_nxt),
    .pattern (pattern),
    .mask    (mask),
    .hit     (hit)
  );

  // A config load wins over the stream, so the bit presented alongside it is discarded.
  always_comb begin
    accept    = in_valid && !cfg_load;
    complete  = accept && ((state == ARMED) || (fill == FILL_LAST));
    match     = complete && hit;
    state_nxt = state;
    if (cfg_load) begin
      state_nxt = FILL;
    end else if (match && !overlap) begin
      state_nxt = FILL;
    end else if (complete) begin
      state_nxt = ARMED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist          <= '0;
      fill          <= '0;
      pattern       <= RST_PAT;
      mask          <= RST_MASK;
      overlap       <= 1'b1;
      pattern_found <= 1'b0;
    end else begin
      pattern_found <= match;
      if (cfg_load) begin
        pattern <= cfg_pattern;
        mask    <= cfg_mask;
        overlap <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
      end else if (match && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else if (accept) begin
        hist <= hist_nxt;
        if (fill != FILL_FULL) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

  assign busy_fill = (state == FILL);

`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (pattern_found && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb/tb_pattern_detector_param.sv - self-checking bench for pattern_detector_param with a queue-based reference model
module tb_pattern_detector_param;

  localparam int W = 5;
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic         in_valid    = 1'b0;
  logic         stream_in   = 1'b0;
  logic         cfg_load    = 1'b0;
  logic [W-1:0] cfg_pattern = '0;
  logic [W-1:0] cfg_mask    = '0;
  logic         cfg_overlap = 1'b0;
  logic         found;
  logic         busy;
  logic         cfg_load3    = 1'b0;
  logic [2:0]   cfg_pattern3 = '0;
  logic [2:0]   cfg_mask3    = '0;
  logic         cfg_overlap3 = 1'b0;
  logic         found3;
  logic         busy3;
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
  logic [TB_CNT_W-1:0] cnt;
  logic [TB_CNT_W-1:0] cnt3;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pattern_detector_param #(
    .PAT_W(W), .RST_PAT(5'b11010), .RST_MASK(5'b11111), .CNT_W(TB_CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stream_in(stream_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .pattern_found(found), .busy_fill(busy)
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    , .match_cnt(cnt)
`endif
  );

  pattern_detector_param #(
    .PAT_W(3), .RST_PAT(3'b101), .RST_MASK(3'b111), .CNT_W(TB_CNT_W)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stream_in(stream_in),
    .cfg_load(cfg_load3), .cfg_pattern(cfg_pattern3), .cfg_mask(cfg_mask3),
    .cfg_overlap(cfg_overlap3), .pattern_found(found3), .busy_fill(busy3)
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    , .match_cnt(cnt3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bits accepted since the last clear, at most W kept.
  bit           hq[$];
  logic [W-1:0] m_pat;
  logic [W-1:0] m_mask;
  bit           m_ovl;
  bit           exp_found;
  int           exp_cnt;

  function automatic bit window_hit();
    for (int i = 0; i < W; i++) begin
      if (m_mask[W-1-i] && (hq[i] != m_pat[W-1-i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hq.delete();
      m_pat     = 5'b11010;
      m_mask    = '1;
      m_ovl     = 1'b1;
      exp_found = 1'b0;
      exp_cnt   = 0;
    end else begin
      if (exp_found && (exp_cnt < (1 << TB_CNT_W) - 1)) exp_cnt++;
      exp_found = 1'b0;
      if (cfg_load) begin
        m_pat  = cfg_pattern;
        m_mask = cfg_mask;
        m_ovl  = cfg_overlap;
        hq.delete();
      end else if (in_valid) begin
        hq.push_back(stream_in);
        if (hq.size() > W) void'(hq.pop_front());
        if ((hq.size() == W) && window_hit()) begin
          exp_found = 1'b1;
          if (!m_ovl) hq.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("found_vs_model", {31'b0, found}, {31'b0, exp_found});
      check("busy_vs_model", {31'b0, busy}, {31'b0, (hq.size() < W)});
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
      check("cnt_vs_model", 32'(cnt), 32'(exp_cnt));
`endif
    end
  end

  task automatic send_bits(input logic [31:0] bits, input int n,
                           output logic [31:0] hit5, output logic [31:0] hit3);
    hit5 = '0;
    hit3 = '0;
    for (int k = 0; k < n; k++) begin
      in_valid  = 1'b1;
      stream_in = bits[n-1-k];
      @(negedge clk);
      hit5[k] = found;
      hit3[k] = found3;
    end
    in_valid = 1'b0;
  endtask

  task automatic load5(input logic [W-1:0] pat, input logic [W-1:0] msk, input logic ovl);
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic load3(input logic [2:0] pat, input logic [2:0] msk, input logic ovl);
    cfg_pattern3 = pat;
    cfg_mask3    = msk;
    cfg_overlap3 = ovl;
    cfg_load3    = 1'b1;
    @(negedge clk);
    cfg_load3 = 1'b0;
  endtask

  logic [31:0] h5;
  logic [31:0] h3;
  logic [W-1:0] pat5;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_found", {31'b0, found}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    check("rst_cnt", 32'(cnt), 32'd0);
`endif

    send_bits(32'b11010, 5, h5, h3);
    check("t1_pulses", h5, 32'h10);

    load5(5'b11010, 5'b11111, 1'b1);
    send_bits(32'b1101011010, 10, h5, h3);
    check("t2_pulses", h5, 32'h210);

    load3(3'b101, 3'b111, 1'b1);
    send_bits(32'b10101, 5, h5, h3);
    check("t3_overlap", h3, 32'h14);
    load3(3'b101, 3'b111, 1'b0);
    send_bits(32'b10101, 5, h5, h3);
    check("t3_no_overlap", h3, 32'h04);

    load5(5'b01001, 5'b01001, 1'b1);
    send_bits(32'b01111, 5, h5, h3);
    check("t4_dontcare_ones", h5, 32'h10);
    load5(5'b01001, 5'b01001, 1'b1);
    send_bits(32'b01001, 5, h5, h3);
    check("t4_exact", h5, 32'h10);
    load5(5'b01001, 5'b01001, 1'b1);
    send_bits(32'b00111, 5, h5, h3);
    check("t4_no_match", h5, 32'h0);

    load5(5'b11010, 5'b11111, 1'b1);
    pat5 = 5'b11010;
    for (int k = 0; k < 5; k++) begin
      in_valid  = 1'b1;
      stream_in = pat5[4-k];
      @(negedge clk);
      in_valid = 1'b0;
      check("t5_found_bit", {31'b0, found}, {31'b0, (k == 4)});
      check("t5_busy_bit", {31'b0, busy}, {31'b0, (k < 4)});
      repeat (1 + k % 2) @(negedge clk);
      check("t5_found_gap", {31'b0, found}, 32'd0);
    end

    load5(5'b11010, 5'b11111, 1'b1);
    send_bits(32'b110, 3, h5, h3);
    in_valid  = 1'b1;
    stream_in = 1'b1;
    load5(5'b11010, 5'b11111, 1'b1);
    in_valid = 1'b0;
    check("t6_busy_after_load", {31'b0, busy}, 32'd1);
    send_bits(32'b1010, 4, h5, h3);
    check("t6_dropped_bit", h5, 32'h0);
    check("t6_still_filling", {31'b0, busy}, 32'd1);

    load5(5'b00000, 5'b00000, 1'b1);
    send_bits(32'h1A5, 9, h5, h3);
    check("mask0_every_bit", h5, 32'h1F0);
    @(negedge clk);
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    check("cnt_saturates", 32'(cnt), 32'd3);
`endif

    load5(5'b11010, 5'b11111, 1'b1);
    send_bits(32'b1101, 4, h5, h3);
    in_valid  = 1'b1;
    stream_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_found", {31'b0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_found", {31'b0, found}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd1);
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    check("async_rst_cnt", 32'(cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 600; c++) begin
      cfg_load = ($urandom_range(0, 24) == 0);
      if (cfg_load) begin
        cfg_pattern = W'($urandom);
        cfg_mask    = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom & $urandom);
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      stream_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    cfg_load = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
